seg_display_bcd: RTL and testbench

Parametrised successor to the team's 4-digit seven-segment multiplexer plus combinational divide/modulo decimal split. Takes a binary value and converts it to BCD sequentially (shift-add-3, one bit per cycle). It commits the result atomically, flags values too large to show, optionally blanks leading zeros, and scans DIGITS active-low anodes from a synchronous refresh tick (no derived clock). It sits between sensor or measurement logic (e.g. a distance reading) and the board DISPLAY/DIGIT pins.

---
 rtl/seg_display_bcd.sv | 168 ++++++++++++++++
 tb/tb_seg_display_bcd.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3) with atomic commit, overflow dash,
// optional leading-zero blanking and a tick-driven active-low digit scanner.
module seg_display_bcd #(
    parameter int DIGITS    = 4,
    parameter int BIN_W     = 20,
    parameter int REFRESH_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value,
    input  logic              freeze,
    input  logic              blank_en,
    output logic [6:0]        display,
    output logic [DIGITS-1:0] digit,
    output logic              busy,
    output logic              overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BIN_W-1:0]     bin_sh;
    logic [BCD_W-1:0]     bcd_work;
    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_q;
    logic                 ovf_work;
    logic [CNT_W-1:0]     bit_cnt;

    logic [REFRESH_W-1:0] refresh_cnt;
    logic                 tick_p0;
    logic [IDX_W-1:0]     scan_idx;
    logic [6:0]           seg_p0;
    logic [DIGITS-1:0]    digit_p0;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!freeze) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign bcd_adj = add3(bcd_work);

    // Conversion datapath: any 1 pushed out of the top digit means the value needs more digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_sh   <= '0;
            bcd_work <= '0;
            ovf_work <= 1'b0;
            bit_cnt  <= '0;
            bcd_q    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!freeze) begin
                        bin_sh   <= value;
                        bcd_work <= '0;
                        ovf_work <= 1'b0;
                        bit_cnt  <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    bcd_work <= {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
                    bin_sh   <= {bin_sh[BIN_W-2:0], 1'b0};
                    ovf_work <= ovf_work | bcd_adj[BCD_W-1];
                    bit_cnt  <= bit_cnt - CNT_W'(1);
                end
                COMMIT: begin
                    bcd_q    <= bcd_work;
                    overflow <= ovf_work;
                end
                default: ;
            endcase
        end
    end

    assign tick_p0  = &refresh_cnt;
    assign digit_p0 = ~(DIGITS'(1) << scan_idx);

    always_comb begin
        logic [3:0] cur_nib;
        logic       upper_zero;
        cur_nib    = '0;
        upper_zero = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_nib    = bcd_q[4*k +: 4];
                upper_zero = ((bcd_q >> (4*k)) == '0);
            end
        end
        if (overflow) begin
            seg_p0 = SEG_DASH;
        end else if (blank_en && (scan_idx != '0) && upper_zero) begin
            seg_p0 = SEG_BLANK;
        end else begin
            seg_p0 = seg7(cur_nib);
        end
    end

    // Scan stage: segments and anodes register together on the refresh tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            display     <= SEG_BLANK;
            digit       <= '1;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_W'(1);
            if (tick_p0) begin
                display <= seg_p0;
                digit   <= digit_p0;
                if (scan_idx == IDX_W'(DIGITS - 1)) begin
                    scan_idx <= '0;
                end else begin
                    scan_idx <= scan_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_display_bcd.sv
// Randomised scoreboard bench for seg_display_bcd: conversions are queued as issued and
// checked against a decimal-arithmetic display model when the DUT commits.
module tb_seg_display_bcd;

    localparam int DIGITS    = 4;
    localparam int BIN_W     = 20;
    localparam int REFRESH_W = 3;
    localparam int unsigned LIMIT = 10000;

    logic              clk = 1'b0;
    logic              rst;
    logic [BIN_W-1:0]  value;
    logic              freeze;
    logic              blank_en;
    logic [6:0]        display;
    logic [DIGITS-1:0] digit;
    logic              busy;
    logic              overflow;

    typedef struct {
        int unsigned val;
        bit          blank;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg_display_bcd #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_W(REFRESH_W)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .freeze(freeze), .blank_en(blank_en),
        .display(display), .digit(digit), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(input int unsigned v, input int k, input bit blank);
        int unsigned p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v >= LIMIT) return 7'b0111111;
        if (blank && k > 0 && v < p) return 7'b1111111;
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_conv(input int unsigned v, input bit b, input bit push);
        exp_t e;
        @(negedge clk);
        value    = BIN_W'(v);
        blank_en = b;
        freeze   = 1'b0;
        if (push) begin
            e.val   = v;
            e.blank = b;
            sb_q.push_back(e);
        end
        @(negedge clk);
        freeze = 1'b1;
    endtask

    task automatic convert(input int unsigned v, input bit b);
        start_conv(v, b, 1'b1);
        wait_cycles(90);
    endtask

    // Monitor: a busy fall outside reset marks a commit; then verify one full scan.
    initial begin
        exp_t       e;
        bit         pb;
        logic [3:0] prev_d;
        logic [3:0] exp_dig;
        int         k;
        int         prev_k;
        int         n;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pb = 1'b0;
            end else begin
                if (pb && !busy) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: got commit expected none at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("overflow", 32'(overflow), 32'(e.val >= LIMIT));
                        prev_d = digit;
                        prev_k = 0;
                        for (int t = 0; t < DIGITS; t++) begin
                            n = 0;
                            while (digit === prev_d && n < 12) begin
                                @(negedge clk);
                                n++;
                            end
                            if (digit === prev_d) begin
                                checks++;
                                errors++;
                                $display("FAIL tick_timeout: got digit %0h unchanged expected a tick", digit);
                                break;
                            end
                            prev_d = digit;
                            k = 0;
                            for (int i = DIGITS - 1; i >= 0; i--) if (!digit[i]) k = i;
                            exp_dig = ~(4'b0001 << k);
                            chk("digit_onehot", 32'(digit), 32'(exp_dig));
                            if (t > 0) chk("scan_order", k, (prev_k + 1) % DIGITS);
                            chk($sformatf("seg_v%0d_k%0d_b%0d", e.val, k, e.blank),
                                32'(display), 32'(model_seg(e.val, k, e.blank)));
                            prev_k = k;
                        end
                    end
                end
                pb = busy;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        int unsigned v;
        int          n;
        rst      = 1'b0;
        value    = BIN_W'(1234);
        freeze   = 1'b0;
        blank_en = 1'b0;
        wait_cycles(3);
        chk("reset_display", 32'(display), 32'h7F);
        chk("reset_digit", 32'(digit), 32'hF);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);

        e.val = 1234; e.blank = 1'b0;
        sb_q.push_back(e);
        rst = 1'b1;
        @(negedge clk);
        chk("busy_after_release", 32'(busy), 32'h1);
        freeze = 1'b1;
        wait_cycles(90);

        convert(7, 1'b1);
        convert(7, 1'b0);
        convert(10000, 1'b1);
        convert(9999, 1'b1);
        convert(0, 1'b1);
        convert(0, 1'b0);
        convert(1048575, 1'b0);
        convert(1000, 1'b1);

        // freeze raised while shifting; value changes must not leak into this conversion
        start_conv(42, 1'b1, 1'b1);
        wait_cycles(3);
        chk("busy_mid_shift", 32'(busy), 32'h1);
        value = BIN_W'(99);
        wait_cycles(40);
        chk("freeze_park", 32'(busy), 32'h0);
        wait_cycles(50);
        convert(99, 1'b1);

        // asynchronous reset in the middle of a conversion
        start_conv(5555, 1'b0, 1'b0);
        wait_cycles(8);
        rst = 1'b0;
        #1;
        chk("midreset_display", 32'(display), 32'h7F);
        chk("midreset_digit", 32'(digit), 32'hF);
        chk("midreset_busy", 32'(busy), 32'h0);
        chk("midreset_overflow", 32'(overflow), 32'h0);
        wait_cycles(3);
        value    = BIN_W'(321);
        blank_en = 1'b1;
        freeze   = 1'b0;
        e.val = 321; e.blank = 1'b1;
        sb_q.push_back(e);
        rst = 1'b1;
        @(negedge clk);
        chk("busy_after_midreset", 32'(busy), 32'h1);
        freeze = 1'b1;
        wait_cycles(90);

        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, (1 << BIN_W) - 1);
                1:       v = $urandom_range(0, 99);
                default: v = $urandom_range(0, 9999);
            endcase
            convert(v, 1'($urandom_range(0, 1)));
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
